clk_div_gen: RTL and testbench

Multi-channel, runtime-programmable clock/strobe divider generating the sample-rate clocks (e.g. 20 kHz from 10 MHz) for the FIR/IIR filter chains. Each channel divides `clk` by a programmable period with programmable high time and emits both a divided clock level and a one-cycle rising-edge strobe. Reconfiguration is glitch-free: new settings take effect only at a period boundary. At defaults, channel output is cycle-identical to the legacy fixed 20 kHz generator.

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_gen_if.sv | 27 ++
 rtl/clk_div_chan.sv | 99 +++++++++
 rtl/clk_div_gen.sv | 41 ++++
 tb/tb_clk_div_gen.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared defaults and config validity rule for the clock divider
package clk_div_pkg;

  localparam int CNT_W_DEF = 14;
  localparam int DIV_DEF   = 500;
  localparam int HI_DEF    = 250;

  // A usable config needs at least one low and one high cycle per period.
  function automatic logic cfg_valid(input logic [31:0] div, input logic [31:0] hi);
    return (div >= 32'd2) && (hi >= 32'd1) && (hi < div);
  endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - control and output bundle of the multi-channel clock divider
interface clk_div_gen_if
  import clk_div_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int CNT_W = CNT_W_DEF
);

  logic [NCH-1:0]       en;
  logic [NCH-1:0]       load;
  logic [NCH*CNT_W-1:0] div_in;
  logic [NCH*CNT_W-1:0] hi_in;
  logic [NCH-1:0]       clk_out;
  logic [NCH-1:0]       stb;
  logic [NCH-1:0]       cfg_err;

  modport master (
    output en, load, div_in, hi_in,
    input  clk_out, stb, cfg_err
  );

  modport slave (
    input  en, load, div_in, hi_in,
    output clk_out, stb, cfg_err
  );

endinterface

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, active/shadow config, registered outputs
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DIV_DEF,
  parameter int DEF_HI  = HI_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_hi,
  output logic             o_clk_out,
  output logic             o_stb,
  output logic             o_cfg_err
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_hi;
  logic [CNT_W-1:0] r_sdiv;
  logic [CNT_W-1:0] r_shi;
  logic             r_pend;
  logic             r_clk_out;
  logic             r_stb;
  logic             r_cfg_err;

  logic             w_valid;
  logic             w_wrap;
  logic             w_boundary;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_hi_nxt;
  logic [CNT_W-1:0] w_sdiv_nxt;
  logic [CNT_W-1:0] w_shi_nxt;
  logic             w_pend_nxt;
  logic [CNT_W-1:0] w_thr;

  // A stopped channel is always at a period boundary, so config may switch freely there.
  always_comb begin
    w_valid    = cfg_valid(32'(i_div), 32'(i_hi));
    w_wrap     = i_en && (r_cnt == r_div - CNT_W'(1));
    w_boundary = !i_en || w_wrap;
    w_cnt_nxt  = w_boundary ? '0 : r_cnt + CNT_W'(1);
    w_div_nxt  = r_div;
    w_hi_nxt   = r_hi;
    w_sdiv_nxt = r_sdiv;
    w_shi_nxt  = r_shi;
    w_pend_nxt = r_pend;
    if (i_load && w_valid) begin
      if (w_boundary) begin
        w_div_nxt  = i_div;
        w_hi_nxt   = i_hi;
        w_pend_nxt = 1'b0;
      end else begin
        w_sdiv_nxt = i_div;
        w_shi_nxt  = i_hi;
        w_pend_nxt = 1'b1;
      end
    end else if (r_pend && w_boundary) begin
      w_div_nxt  = r_sdiv;
      w_hi_nxt   = r_shi;
      w_pend_nxt = 1'b0;
    end
    w_thr = w_div_nxt - w_hi_nxt;
  end

  // Outputs are decoded from the next counter value so they line up with r_cnt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_div     <= CNT_W'(DEF_DIV);
      r_hi      <= CNT_W'(DEF_HI);
      r_sdiv    <= CNT_W'(DEF_DIV);
      r_shi     <= CNT_W'(DEF_HI);
      r_pend    <= 1'b0;
      r_clk_out <= 1'b0;
      r_stb     <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_hi      <= w_hi_nxt;
      r_sdiv    <= w_sdiv_nxt;
      r_shi     <= w_shi_nxt;
      r_pend    <= w_pend_nxt;
      r_clk_out <= i_en && (w_cnt_nxt >= w_thr);
      r_stb     <= i_en && (w_cnt_nxt == w_thr);
      r_cfg_err <= i_load && !w_valid;
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_stb     = r_stb;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - multi-channel programmable clock/strobe divider top
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DIV_DEF,
  parameter int DEF_HI  = HI_DEF
) (
  input  logic         clk,
  input  logic         rst,
  clk_div_gen_if.slave bus
);

  logic [NCH-1:0] w_clk_out;
  logic [NCH-1:0] w_stb;
  logic [NCH-1:0] w_cfg_err;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV),
      .DEF_HI  (DEF_HI)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_en      (bus.en[g]),
      .i_load    (bus.load[g]),
      .i_div     (bus.div_in[g*CNT_W +: CNT_W]),
      .i_hi      (bus.hi_in[g*CNT_W +: CNT_W]),
      .o_clk_out (w_clk_out[g]),
      .o_stb     (w_stb[g]),
      .o_cfg_err (w_cfg_err[g])
    );
  end

  assign bus.clk_out = w_clk_out;
  assign bus.stb     = w_stb;
  assign bus.cfg_err = w_cfg_err;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - self-checking bench for clk_div_gen against a timestamp reference model
module tb_clk_div_gen;

  localparam int NCH   = 2;
  localparam int CNT_W = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  clk_div_gen_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  clk_div_gen #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(500), .DEF_HI(250)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: each channel remembers the cycle its current period began; position is elapsed time.
  longint m_cyc;
  longint m_start [NCH];
  int     m_div   [NCH];
  int     m_hi    [NCH];
  int     m_sdiv  [NCH];
  int     m_shi   [NCH];
  bit     m_pend  [NCH];
  bit     m_err   [NCH];

  function automatic int pos(int c);
    return int'(m_cyc - m_start[c]);
  endfunction

  function automatic logic [NCH-1:0] exp_clk_v();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = (pos(c) >= m_div[c] - m_hi[c]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_stb_v();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = (pos(c) == m_div[c] - m_hi[c]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_err_v();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_err[c];
    return v;
  endfunction

  task automatic model_reset();
    m_cyc = 0;
    for (int c = 0; c < NCH; c++) begin
      m_start[c] = 0;
      m_div[c] = 500; m_hi[c] = 250;
      m_sdiv[c] = 500; m_shi[c] = 250;
      m_pend[c] = 1'b0; m_err[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    int d, h;
    bit en, ld, wrap, ok;
    for (int c = 0; c < NCH; c++) begin
      d    = int'(bus.div_in[c*CNT_W +: CNT_W]);
      h    = int'(bus.hi_in[c*CNT_W +: CNT_W]);
      en   = bus.en[c];
      ld   = bus.load[c];
      wrap = en && (pos(c) == m_div[c] - 1);
      ok   = (d >= 2) && (h >= 1) && (h < d);
      m_err[c] = ld && !ok;
      if (ld && ok) begin
        if (!en || wrap) begin
          m_div[c] = d; m_hi[c] = h; m_pend[c] = 1'b0;
        end else begin
          m_sdiv[c] = d; m_shi[c] = h; m_pend[c] = 1'b1;
        end
      end else if (m_pend[c] && (!en || wrap)) begin
        m_div[c] = m_sdiv[c]; m_hi[c] = m_shi[c]; m_pend[c] = 1'b0;
      end
      if (!en || wrap) m_start[c] = m_cyc + 1;
    end
    m_cyc++;
  endtask

  task automatic tick();
    if (rst) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(int c, int d, int h);
    bus.div_in[c*CNT_W +: CNT_W] = CNT_W'(d);
    bus.hi_in[c*CNT_W +: CNT_W]  = CNT_W'(h);
    bus.load[c] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.en = '0; bus.load = '0; bus.div_in = '0; bus.hi_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.clk_out !== 2'b00) begin errors++; $display("FAIL reset_clk_out got %b want 00", bus.clk_out); end
    checks++; if (bus.stb !== 2'b00) begin errors++; $display("FAIL reset_stb got %b want 00", bus.stb); end
    checks++; if (bus.cfg_err !== 2'b00) begin errors++; $display("FAIL reset_cfg_err got %b want 00", bus.cfg_err); end
    bus.en = 2'b11;
    tick();
    checks++; if (bus.clk_out !== 2'b00) begin errors++; $display("FAIL reset_en_clk_out got %b want 00", bus.clk_out); end
    rst = 1'b1;
  endtask

  task automatic test_defaults();
    int last_rise, last_fall, last_stb, first_stb, hi_len, lo_len, gap;
    logic prev;
    last_rise = -1; last_fall = -1; last_stb = -1; first_stb = -1;
    hi_len = -1; lo_len = -1; gap = -1; prev = 1'b0;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      checks++; if (bus.clk_out !== exp_clk_v()) begin errors++; $display("FAIL def_clk_out cyc %0d got %b want %b", i, bus.clk_out, exp_clk_v()); end
      checks++; if (bus.stb !== exp_stb_v()) begin errors++; $display("FAIL def_stb cyc %0d got %b want %b", i, bus.stb, exp_stb_v()); end
      checks++; if (bus.cfg_err !== exp_err_v()) begin errors++; $display("FAIL def_cfg_err cyc %0d got %b want %b", i, bus.cfg_err, exp_err_v()); end
      if (bus.clk_out[0] && !prev) begin
        if (last_fall >= 0) lo_len = i - last_fall;
        last_rise = i;
      end
      if (!bus.clk_out[0] && prev && last_rise >= 0) begin
        hi_len = i - last_rise;
        last_fall = i;
      end
      if (bus.stb[0]) begin
        if (last_stb >= 0) gap = i - last_stb;
        if (first_stb < 0) first_stb = i;
        last_stb = i;
      end
      prev = bus.clk_out[0];
    end
    checks++; if (first_stb !== 250) begin errors++; $display("FAIL def_first_stb got %0d want 250", first_stb); end
    checks++; if (hi_len !== 250) begin errors++; $display("FAIL def_high_len got %0d want 250", hi_len); end
    checks++; if (lo_len !== 250) begin errors++; $display("FAIL def_low_len got %0d want 250", lo_len); end
    checks++; if (gap !== 500) begin errors++; $display("FAIL def_stb_gap got %0d want 500", gap); end
  endtask

  task automatic test_midload();
    int g, last_rise, last_fall, last_stb, hi_len, lo_len, gap, wrap_at;
    logic prev;
    g = 0;
    while (pos(0) != 100 && g < 1000) begin tick(); g++; end
    checks++; if (g >= 1000) begin errors++; $display("FAIL mid_wait timeout got %0d want <1000", g); end
    set_cfg(0, 10, 3);
    tick();
    bus.load = '0;
    last_rise = -1; last_fall = -1; last_stb = -1; hi_len = -1; lo_len = -1; gap = -1; wrap_at = -1;
    prev = bus.clk_out[0];
    for (int i = 1; i <= 500; i++) begin
      tick();
      checks++; if (bus.clk_out !== exp_clk_v()) begin errors++; $display("FAIL mid_clk_out cyc %0d got %b want %b", i, bus.clk_out, exp_clk_v()); end
      checks++; if (bus.stb !== exp_stb_v()) begin errors++; $display("FAIL mid_stb cyc %0d got %b want %b", i, bus.stb, exp_stb_v()); end
      if (!bus.clk_out[0] && prev && wrap_at < 0) wrap_at = i;
      if (bus.clk_out[0] && !prev) begin
        if (last_fall >= 0) lo_len = i - last_fall;
        last_rise = i;
      end
      if (!bus.clk_out[0] && prev) begin
        if (last_rise >= 0) hi_len = i - last_rise;
        last_fall = i;
      end
      if (bus.stb[0]) begin
        if (last_stb >= 0) gap = i - last_stb;
        last_stb = i;
      end
      prev = bus.clk_out[0];
    end
    checks++; if (wrap_at !== 399) begin errors++; $display("FAIL mid_old_period_end got %0d want 399", wrap_at); end
    checks++; if (hi_len !== 3) begin errors++; $display("FAIL mid_high_len got %0d want 3", hi_len); end
    checks++; if (lo_len !== 7) begin errors++; $display("FAIL mid_low_len got %0d want 7", lo_len); end
    checks++; if (gap !== 10) begin errors++; $display("FAIL mid_stb_gap got %0d want 10", gap); end
  endtask

  task automatic test_invalid();
    int last_stb, gap;
    int bad_d [3] = '{1, 10, 10};
    int bad_h [3] = '{1, 0, 10};
    for (int k = 0; k < 3; k++) begin
      set_cfg(1, bad_d[k], bad_h[k]);
      tick();
      bus.load = '0;
      checks++; if (bus.cfg_err !== 2'b10) begin errors++; $display("FAIL inv_err_pulse case %0d got %b want 10", k, bus.cfg_err); end
      tick();
      checks++; if (bus.cfg_err !== 2'b00) begin errors++; $display("FAIL inv_err_clear case %0d got %b want 00", k, bus.cfg_err); end
    end
    last_stb = -1; gap = -1;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      checks++; if (bus.clk_out !== exp_clk_v()) begin errors++; $display("FAIL inv_clk_out cyc %0d got %b want %b", i, bus.clk_out, exp_clk_v()); end
      checks++; if (bus.stb !== exp_stb_v()) begin errors++; $display("FAIL inv_stb cyc %0d got %b want %b", i, bus.stb, exp_stb_v()); end
      if (bus.stb[1]) begin
        if (last_stb >= 0) gap = i - last_stb;
        last_stb = i;
      end
    end
    checks++; if (gap !== 500) begin errors++; $display("FAIL inv_period got %0d want 500", gap); end
  endtask

  task automatic test_wrap_load();
    int g, highs, last_stb, gap;
    g = 0;
    while (pos(1) != 499 && g < 1000) begin tick(); g++; end
    checks++; if (g >= 1000) begin errors++; $display("FAIL wrap_wait timeout got %0d want <1000", g); end
    set_cfg(1, 8, 4);
    tick();
    bus.load = '0;
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      checks++; if (bus.clk_out !== exp_clk_v()) begin errors++; $display("FAIL wrap_clk_out cyc %0d got %b want %b", i, bus.clk_out, exp_clk_v()); end
      highs += int'(bus.clk_out[1]);
    end
    checks++; if (highs !== 4) begin errors++; $display("FAIL wrap_high_count got %0d want 4", highs); end
    tick();
    set_cfg(1, 8, 4);
    tick();
    set_cfg(1, 6, 1);
    tick();
    bus.load = '0;
    last_stb = -1; gap = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++; if (bus.clk_out !== exp_clk_v()) begin errors++; $display("FAIL dbl_clk_out cyc %0d got %b want %b", i, bus.clk_out, exp_clk_v()); end
      checks++; if (bus.stb !== exp_stb_v()) begin errors++; $display("FAIL dbl_stb cyc %0d got %b want %b", i, bus.stb, exp_stb_v()); end
      if (bus.stb[1]) begin
        if (last_stb >= 0) gap = i - last_stb;
        last_stb = i;
      end
    end
    checks++; if (gap !== 6) begin errors++; $display("FAIL dbl_period got %0d want 6", gap); end
  endtask

  task automatic test_en_drop();
    int g, n;
    g = 0;
    while (pos(0) != 8 && g < 100) begin tick(); g++; end
    checks++; if (g >= 100 || bus.clk_out[0] !== 1'b1) begin errors++; $display("FAIL endrop_setup got clk_out %b wait %0d want 1", bus.clk_out[0], g); end
    bus.en[0] = 1'b0;
    tick();
    checks++; if (bus.clk_out[0] !== 1'b0) begin errors++; $display("FAIL endrop_clk_out got %b want 0", bus.clk_out[0]); end
    checks++; if (bus.stb !== exp_stb_v()) begin errors++; $display("FAIL endrop_stb got %b want %b", bus.stb, exp_stb_v()); end
    repeat (5) tick();
    checks++; if (bus.clk_out !== exp_clk_v()) begin errors++; $display("FAIL endrop_hold got %b want %b", bus.clk_out, exp_clk_v()); end
    bus.en[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.stb[0] && n < 50);
    checks++; if (n !== 7) begin errors++; $display("FAIL reen_first_stb got %0d want 7", n); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(63) == 0) bus.en[c] = ~bus.en[c];
        bus.load[c] = 1'b0;
        if ($urandom_range(15) == 0)
          set_cfg(c, int'($urandom_range(12)), int'($urandom_range(12)));
      end
      tick();
      checks++; if (bus.clk_out !== exp_clk_v()) begin errors++; $display("FAIL rnd_clk_out cyc %0d got %b want %b", i, bus.clk_out, exp_clk_v()); end
      checks++; if (bus.stb !== exp_stb_v()) begin errors++; $display("FAIL rnd_stb cyc %0d got %b want %b", i, bus.stb, exp_stb_v()); end
      checks++; if (bus.cfg_err !== exp_err_v()) begin errors++; $display("FAIL rnd_cfg_err cyc %0d got %b want %b", i, bus.cfg_err, exp_err_v()); end
    end
    bus.load = '0;
    bus.en = 2'b11;
  endtask

  task automatic test_async_reset();
    int g;
    set_cfg(0, 500, 250);
    set_cfg(1, 4, 1);
    tick();
    bus.load = '0;
    g = 0;
    while (!(m_div[0] == 500 && pos(0) == 300) && g < 2000) begin
      tick(); g++;
      checks++; if (bus.clk_out !== exp_clk_v()) begin errors++; $display("FAIL ar_clk_out cyc %0d got %b want %b", g, bus.clk_out, exp_clk_v()); end
    end
    checks++; if (g >= 2000 || bus.clk_out[0] !== 1'b1) begin errors++; $display("FAIL ar_setup got clk_out %b wait %0d want 1", bus.clk_out[0], g); end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.clk_out !== 2'b00) begin errors++; $display("FAIL ar_clk_out_now got %b want 00", bus.clk_out); end
    checks++; if (bus.stb !== 2'b00) begin errors++; $display("FAIL ar_stb_now got %b want 00", bus.stb); end
    checks++; if (bus.cfg_err !== 2'b00) begin errors++; $display("FAIL ar_cfg_err_now got %b want 00", bus.cfg_err); end
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      tick();
      checks++; if (bus.clk_out !== exp_clk_v()) begin errors++; $display("FAIL ar_post_clk_out cyc %0d got %b want %b", i, bus.clk_out, exp_clk_v()); end
      checks++; if (bus.stb !== exp_stb_v()) begin errors++; $display("FAIL ar_post_stb cyc %0d got %b want %b", i, bus.stb, exp_stb_v()); end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_midload();
    test_invalid();
    test_wrap_load();
    test_en_drop();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
